// File: rtl/usb_tx_arbiter.sv
// Round-robin packet scheduler sharing the single upstream FIFO write port between
// NUM_SRC producers; every grant is framed as header, data burst and trailer.
module usb_tx_arbiter #(
    parameter int         DATA_WIDTH = 32,
    parameter int         NUM_SRC    = 4,
    parameter int         MAX_BURST  = 64,
    parameter logic [7:0] HDR_TAG    = 8'hA5,
    parameter logic [7:0] TRL_TAG    = 8'h5A
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          arb_enable,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic                          user_ready,
    output logic                          user_en,
    output logic [DATA_WIDTH-1:0]         user_data,
    output logic                          busy,
    output logic [15:0]                   pkt_seq
);

    localparam int          GW          = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [15:0] MAX_BURST_C = 16'(MAX_BURST);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_TRL  = 2'd3;

    logic [1:0]            state_r;
    logic [GW-1:0]         grant_r;
    logic [GW-1:0]         last_grant_r;
    logic [15:0]           count_r;
    logic [15:0]           pkt_seq_r;
    logic                  user_en_r;
    logic [DATA_WIDTH-1:0] user_data_r;

    logic                  pick_found_s;
    logic [GW-1:0]         pick_s;
    logic                  hit_s;
    logic                  sel_valid_s;
    logic [DATA_WIDTH-1:0] sel_data_s;
    logic                  burst_open_s;
    logic                  accept_s;
    logic                  last_word_s;
    logic [NUM_SRC-1:0]    src_ready_s;

    // Header and trailer share one layout: tag byte, source byte, 16-bit field.
    function automatic logic [DATA_WIDTH-1:0] frame_word(
        input logic [7:0]    tag,
        input logic [GW-1:0] src,
        input logic [15:0]   low
    );
        return DATA_WIDTH'({tag, 8'(src), low});
    endfunction

    // Round-robin search: first valid source after the previous winner, wrapping.
    always_comb begin
        pick_found_s = 1'b0;
        pick_s       = '0;
        hit_s        = 1'b0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            for (int g = 0; g < NUM_SRC; g++) begin
                hit_s        = !pick_found_s && src_valid[g] &&
                               (g == ((int'(last_grant_r) + i) % NUM_SRC));
                pick_s       = hit_s ? GW'(g) : pick_s;
                pick_found_s = pick_found_s | hit_s;
            end
        end
    end

    // Route the granted source's valid and data.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_data_s  = '0;
        for (int g = 0; g < NUM_SRC; g++) begin
            sel_valid_s = (grant_r == GW'(g)) ? src_valid[g] : sel_valid_s;
            sel_data_s  = (grant_r == GW'(g)) ? src_data[g*DATA_WIDTH +: DATA_WIDTH] : sel_data_s;
        end
    end

    // Data handshake: only the granted source sees ready, and only with FIFO room.
    always_comb begin
        burst_open_s = (state_r == ST_DATA) && user_ready && (count_r < MAX_BURST_C);
        src_ready_s  = '0;
        for (int g = 0; g < NUM_SRC; g++) begin
            src_ready_s[g] = burst_open_s && (grant_r == GW'(g));
        end
        accept_s    = burst_open_s && sel_valid_s;
        last_word_s = ((count_r + 16'd1) == MAX_BURST_C);
    end

    // Frame sequencer driving the registered upstream write port.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r      <= ST_IDLE;
            grant_r      <= '0;
            last_grant_r <= GW'(NUM_SRC - 1);
            count_r      <= 16'd0;
            pkt_seq_r    <= 16'd0;
            user_en_r    <= 1'b0;
            user_data_r  <= '0;
        end else begin
            user_en_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (arb_enable && pick_found_s) begin
                        grant_r <= pick_s;
                        count_r <= 16'd0;
                        state_r <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (user_ready) begin
                        user_en_r   <= 1'b1;
                        user_data_r <= frame_word(HDR_TAG, grant_r, pkt_seq_r);
                        state_r     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (accept_s) begin
                        user_en_r   <= 1'b1;
                        user_data_r <= sel_data_s;
                        count_r     <= count_r + 16'd1;
                    end
                    // A stall with valid still high pauses the burst; only a drop or a full burst ends it.
                    if ((accept_s && last_word_s) || !sel_valid_s) begin
                        state_r <= ST_TRL;
                    end
                end
                ST_TRL: begin
                    if (user_ready) begin
                        user_en_r    <= 1'b1;
                        user_data_r  <= frame_word(TRL_TAG, grant_r, count_r);
                        last_grant_r <= grant_r;
                        pkt_seq_r    <= pkt_seq_r + 16'd1;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign src_ready = src_ready_s;
    assign user_en   = user_en_r;
    assign user_data = user_data_r;
    assign busy      = (state_r != ST_IDLE);
    assign pkt_seq   = pkt_seq_r;

endmodule
